player_intent_gen: RTL and testbench
====================================

Name: player_intent_gen

Overview:
Command-side counterpart of the physics engine. It converts raw player buttons into the movingLeft / movingRight / isJumping strobes the physics engine consumes, plus an attack state. Buttons are synchronised and debounced on clk. Outputs change only on the 20 Hz game tick and hold steady between ticks, so the physics engine samples stable levels. One instance sits per player between the button pins and the physics engine.

Parameters:
DB_CYCLES, 16, consecutive clk cycles a synchronised button must hold a level before the debounced value changes (counter width = clog2(DB_CYCLES)+1)
FLOOR_Y, 48, sprite_y value meaning grounded
JUMP_BUF_TICKS, 3, game ticks a jump press is remembered while airborne
ATTACK_TICKS, 4, game ticks the attacking output is high
COOLDOWN_TICKS, 6, game ticks after an attack during which new attack presses are discarded

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-clk-wide game tick enable (20 Hz)
player_no  in  1  0 = left player, 1 = right player
btn_left  in  1  raw asynchronous button
btn_right  in  1  raw asynchronous button
btn_jump  in  1  raw asynchronous button
btn_attack  in  1  raw asynchronous button
sprite_y  in  7  current vertical position from the physics engine
movingLeft  out  1  move-left command
movingRight  out  1  move-right command
isJumping  out  1  jump command, one tick wide
attacking  out  1  high during the attack active phase
facing_right  out  1  1 = facing right
busy  out  1  attack FSM is not IDLE

Behaviour:
- Reset (reset is synchronous, active-high; clock is clk):
  - all outputs 0 except facing_right = ~player_no
  - synchronisers, debounce counters, debounced levels, jump pending and FSM are cleared; FSM goes to IDLE
  - applies even mid-attack or mid-jump-buffer
- Input path, per button:
  - 2-flop synchroniser, then debounce counter
  - counter increments while the synchronised value differs from the debounced value, and clears when they match
  - on reaching DB_CYCLES, the debounced value flips and the counter clears
  - a press is therefore visible at DB_CYCLES+2 clk latency
- Edge detection: rising edges of debounced jump and attack are detected every clk and latched as requests until the next tick consumes them. Multiple edges between ticks collapse to one request.
- Update rule: every output register loads only in a cycle with tick=1. With tick=0 all outputs hold.
- Movement, on tick:
  - movingLeft = dbL & ~dbR & ~attacking_next
  - movingRight = dbR & ~dbL & ~attacking_next
  - both pressed gives neither
  - facing_right is set on movingRight and cleared on movingLeft; otherwise it holds
- Jump, on tick:
  - a new jump request sets pending with buf = JUMP_BUF_TICKS
  - if pending and sprite_y == FLOOR_Y: isJumping = 1 for that tick and pending clears
  - else isJumping = 0; buf decrements, and pending drops when buf reaches 0
  - holding the button never retriggers; a new rising edge is required
  - a request arriving on the same tick it is evaluated counts toward that tick
- Attack FSM (IDLE, ACTIVE, COOLDOWN), advancing only on tick; cnt counts ticks:
  - IDLE: attack request -> ACTIVE, cnt = ATTACK_TICKS-1, attacking = 1 from that tick
  - ACTIVE: cnt==0 -> COOLDOWN, cnt = COOLDOWN_TICKS-1, attacking = 0; else cnt--
  - COOLDOWN: cnt==0 -> IDLE; else cnt--
  - attack requests latched while not in IDLE are discarded on the tick that sees them, so there is no queued attack
- Result: attacking is high for exactly ATTACK_TICKS ticks; the next attack can start no earlier than ATTACK_TICKS+COOLDOWN_TICKS ticks after the previous start.
- busy = (state != IDLE), registered with the FSM.
- Jump and attack are independent; both may fire on the same tick.

Optional Feature:
MOVE_WHILE_ATTACK_EN
- Defined: the ~attacking_next term is dropped, so movement passes through during ACTIVE.
- Undefined (default): movingLeft/movingRight are forced 0 on every tick where attacking will be 1.

Test Plan:
- Reset release, player_no=1, no buttons -> all outputs 0, facing_right=0, busy=0.
- btn_right held 40 clk, then tick -> movingRight=1, facing_right=1. btn_right glitch of 10 clk (< DB_CYCLES=16) -> movingRight stays 0.
- btn_left+btn_right both held, tick -> movingLeft=0, movingRight=0, facing_right unchanged.
- Jump press with sprite_y=48 -> isJumping=1 for exactly one tick, 0 on the next. Jump press with sprite_y=40, then sprite_y=48 on the 2nd tick -> isJumping=1 on that tick. sprite_y=40 held 3 ticks -> request dropped and isJumping never asserts.
- Attack press, then btn_right held -> attacking=1 for 4 ticks with movingRight=0, busy=1 for 10 ticks. A second press at tick 6 -> ignored. A press at tick 11 -> new attack.
- Reset asserted during ACTIVE with a jump pending -> next cycle busy=0, attacking=0; no isJumping on later ticks.

Source files
------------

// File: rtl/player_intent_if.sv
// player_intent_if: button/tick inputs and command outputs between the pins, one intent generator and the physics engine
interface player_intent_if;
    logic       tick;
    logic       player_no;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic       btn_attack;
    logic [6:0] sprite_y;
    logic       movingLeft;
    logic       movingRight;
    logic       isJumping;
    logic       attacking;
    logic       facing_right;
    logic       busy;
    modport master (
        output tick, player_no, btn_left, btn_right, btn_jump, btn_attack, sprite_y,
        input  movingLeft, movingRight, isJumping, attacking, facing_right, busy
    );
    modport slave (
        input  tick, player_no, btn_left, btn_right, btn_jump, btn_attack, sprite_y,
        output movingLeft, movingRight, isJumping, attacking, facing_right, busy
    );
endinterface

// File: rtl/player_intent_gen.sv
// player_intent_gen: debounced buttons -> tick-aligned move/jump/attack commands; define MOVE_WHILE_ATTACK_EN to let movement pass through during an attack
module player_intent_gen #(
    parameter int DB_CYCLES      = 16,
    parameter int FLOOR_Y        = 48,
    parameter int JUMP_BUF_TICKS = 3,
    parameter int ATTACK_TICKS   = 4,
    parameter int COOLDOWN_TICKS = 6
) (
    input logic            clk,
    input logic            reset,
    player_intent_if.slave bus
);
    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam int BW = $clog2(JUMP_BUF_TICKS + 1);
    localparam int AW = $clog2((ATTACK_TICKS > COOLDOWN_TICKS ? ATTACK_TICKS : COOLDOWN_TICKS) + 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;
    logic [3:0]          btn, sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
    logic [3:0][CW-1:0]  cnt_q, cnt_d;
    logic                jreq_q, jreq_d, areq_q, areq_d, jreq, areq;
    logic                pend_q, pend_d, pend, hit, move_ok;
    logic [BW-1:0]       jbuf_q, jbuf_d, jbuf_n;
    state_t              state_q, state_d;
    logic [AW-1:0]       acnt_q, acnt_d;
    logic                ml_q, ml_d, mr_q, mr_d, jump_q, jump_d, face_q, face_d;
    assign btn = {bus.btn_attack, bus.btn_jump, bus.btn_right, bus.btn_left};
    // synchronise each button, then flip its debounced level after DB_CYCLES consecutive disagreeing cycles
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = sync2_q[i] != db_q[i] ? cnt_q[i] + 1'b1 : '0;
            if (cnt_d[i] == CW'(DB_CYCLES)) begin
                db_d[i]  = ~db_q[i];
                cnt_d[i] = '0;
            end
        end
    end
    // rising edges of debounced jump/attack are held until a tick consumes them; an edge in the tick cycle itself still counts
    always_comb begin
        jreq   = jreq_q | (db_d[2] & ~db_q[2]);
        areq   = areq_q | (db_d[3] & ~db_q[3]);
        jreq_d = bus.tick ? 1'b0 : jreq;
        areq_d = bus.tick ? 1'b0 : areq;
    end
    // attack FSM advances only on tick; requests seen outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        if (bus.tick) begin
            case (state_q)
                IDLE: begin
                    state_d = areq ? ACTIVE : IDLE;
                    acnt_d  = areq ? AW'(ATTACK_TICKS - 1) : acnt_q;
                end
                ACTIVE: begin
                    state_d = acnt_q == '0 ? COOLDOWN : ACTIVE;
                    acnt_d  = acnt_q == '0 ? AW'(COOLDOWN_TICKS - 1) : acnt_q - 1'b1;
                end
                COOLDOWN: begin
                    state_d = acnt_q == '0 ? IDLE : COOLDOWN;
                    acnt_d  = acnt_q == '0 ? '0 : acnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end
`ifdef MOVE_WHILE_ATTACK_EN
    assign move_ok = 1'b1;
`else
    assign move_ok = state_d != ACTIVE;
`endif
    // movement, facing and buffered jump all update on tick and hold otherwise
    always_comb begin
        ml_d   = bus.tick ? db_q[0] & ~db_q[1] & move_ok : ml_q;
        mr_d   = bus.tick ? db_q[1] & ~db_q[0] & move_ok : mr_q;
        face_d = !bus.tick ? face_q : mr_d ? 1'b1 : ml_d ? 1'b0 : face_q;
        pend   = pend_q | jreq;
        jbuf_n = jreq ? BW'(JUMP_BUF_TICKS) : jbuf_q;
        hit    = pend & (bus.sprite_y == 7'(FLOOR_Y));
        jump_d = bus.tick ? hit : jump_q;
        pend_d = bus.tick ? pend & ~hit & (jbuf_n > BW'(1)) : pend_q;
        jbuf_d = bus.tick & pend & ~hit ? jbuf_n - 1'b1 : jbuf_q;
    end
    // state registers; reset clears everything and faces each player toward the centre
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            jreq_q  <= 1'b0;
            areq_q  <= 1'b0;
            pend_q  <= 1'b0;
            jbuf_q  <= '0;
            state_q <= IDLE;
            acnt_q  <= '0;
            ml_q    <= 1'b0;
            mr_q    <= 1'b0;
            jump_q  <= 1'b0;
            face_q  <= ~bus.player_no;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            jreq_q  <= jreq_d;
            areq_q  <= areq_d;
            pend_q  <= pend_d;
            jbuf_q  <= jbuf_d;
            state_q <= state_d;
            acnt_q  <= acnt_d;
            ml_q    <= ml_d;
            mr_q    <= mr_d;
            jump_q  <= jump_d;
            face_q  <= face_d;
        end
    end
    assign bus.movingLeft   = ml_q;
    assign bus.movingRight  = mr_q;
    assign bus.isJumping    = jump_q;
    assign bus.attacking    = state_q == ACTIVE;
    assign bus.facing_right = face_q;
    assign bus.busy         = state_q != IDLE;
endmodule

// File: tb/tb_player_intent_gen.sv
// tb_player_intent_gen: movement table plus jump/attack/reset sequences, checked through an expectation queue
module tb_player_intent_gen;
    typedef struct {
        logic ml, mr, ij, att, face, busy;
    } exp_t;
    typedef struct {
        logic l, r;
        int   hold;
        logic glitch;
        logic ml, mr, face;
    } mv_t;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    mv_t  mv[8];
    player_intent_if bus();
    player_intent_gen dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic exp_t mk(logic ml, logic mr, logic ij, logic att, logic face, logic busy);
        exp_t e;
        e.ml = ml; e.mr = mr; e.ij = ij; e.att = att; e.face = face; e.busy = busy;
        return e;
    endfunction
    task automatic cmp(string tag, string name, logic got, logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s.%s: got %b expected %b", tag, name, got, want);
        end
    endtask
    task automatic check(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s.queue: got empty expected entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp(tag, "movingLeft", bus.movingLeft, e.ml);
        cmp(tag, "movingRight", bus.movingRight, e.mr);
        cmp(tag, "isJumping", bus.isJumping, e.ij);
        cmp(tag, "attacking", bus.attacking, e.att);
        cmp(tag, "facing_right", bus.facing_right, e.face);
        cmp(tag, "busy", bus.busy, e.busy);
    endtask
    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulse_tick(string tag, exp_t e);
        sb.push_back(e);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        check(tag);
    endtask
    initial begin
        mv[0] = '{1'b0, 1'b1, 40, 1'b0, 1'b0, 1'b1, 1'b1};
        mv[1] = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b0, 1'b1};
        mv[2] = '{1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1};
        mv[3] = '{1'b1, 1'b0, 40, 1'b0, 1'b1, 1'b0, 1'b0};
        mv[4] = '{1'b1, 1'b1, 40, 1'b0, 1'b0, 1'b0, 1'b0};
        mv[5] = '{1'b0, 1'b1, 40, 1'b0, 1'b0, 1'b1, 1'b1};
        mv[6] = '{1'b1, 1'b1, 40, 1'b0, 1'b0, 1'b0, 1'b1};
        mv[7] = '{1'b0, 1'b0, 40, 1'b0, 1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        bus.tick = 1'b0;
        bus.player_no = 1'b1;
        bus.btn_left = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_jump = 1'b0;
        bus.btn_attack = 1'b0;
        bus.sprite_y = 7'd48;
        wait_clk(3);
        reset = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        check("reset");
        wait_clk(5);
        pulse_tick("idle_tick", mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            bus.btn_left = mv[i].l;
            bus.btn_right = mv[i].r;
            wait_clk(mv[i].hold);
            if (mv[i].glitch) begin
                bus.btn_left = 1'b0;
                bus.btn_right = 1'b0;
                wait_clk(40);
            end
            pulse_tick($sformatf("move%0d", i), mk(mv[i].ml, mv[i].mr, 0, 0, mv[i].face, 0));
        end
        bus.btn_jump = 1'b1;
        wait_clk(40);
        pulse_tick("jump_floor", mk(0, 0, 1, 0, 1, 0));
        wait_clk(5);
        pulse_tick("jump_held", mk(0, 0, 0, 0, 1, 0));
        bus.btn_jump = 1'b0;
        wait_clk(40);
        pulse_tick("jump_release", mk(0, 0, 0, 0, 1, 0));
        bus.sprite_y = 7'd40;
        bus.btn_jump = 1'b1;
        wait_clk(40);
        pulse_tick("jump_air1", mk(0, 0, 0, 0, 1, 0));
        bus.btn_jump = 1'b0;
        bus.sprite_y = 7'd48;
        wait_clk(40);
        pulse_tick("jump_land2", mk(0, 0, 1, 0, 1, 0));
        wait_clk(5);
        pulse_tick("jump_after", mk(0, 0, 0, 0, 1, 0));
        bus.sprite_y = 7'd40;
        bus.btn_jump = 1'b1;
        wait_clk(40);
        pulse_tick("buf_t1", mk(0, 0, 0, 0, 1, 0));
        bus.btn_jump = 1'b0;
        wait_clk(40);
        pulse_tick("buf_t2", mk(0, 0, 0, 0, 1, 0));
        wait_clk(5);
        pulse_tick("buf_t3", mk(0, 0, 0, 0, 1, 0));
        bus.sprite_y = 7'd48;
        wait_clk(5);
        pulse_tick("buf_expired", mk(0, 0, 0, 0, 1, 0));
        wait_clk(5);
        pulse_tick("buf_expired2", mk(0, 0, 0, 0, 1, 0));
        bus.btn_right = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            logic att, bsy;
            att = (k <= 3) || (k == 11);
            bsy = (k <= 9) || (k == 11);
            bus.btn_attack = (k == 0) || (k == 5) || (k == 11);
            wait_clk(40);
            pulse_tick($sformatf("atk%0d", k), mk(0, !att, 0, att, 1, bsy));
        end
        bus.btn_attack = 1'b0;
        bus.sprite_y = 7'd40;
        bus.btn_jump = 1'b1;
        wait_clk(40);
        pulse_tick("pre_reset", mk(0, 0, 0, 1, 1, 1));
        bus.btn_jump = 1'b0;
        bus.btn_right = 1'b0;
        bus.player_no = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 1, 0));
        check("mid_reset");
        bus.sprite_y = 7'd48;
        wait_clk(40);
        for (int k = 0; k < 3; k++) begin
            pulse_tick($sformatf("post_reset%0d", k), mk(0, 0, 0, 0, 1, 0));
            wait_clk(5);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
